player_motion_fsm: RTL

//  Parametrised player-sprite motion controller: keyboard, rope and block contacts in, sprite top-left pixel out.

---
 rtl/player_motion_fsm_if.sv | 33 +++
 rtl/player_motion_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/player_motion_fsm_if.sv
// Player motion controller signal bundle: frame strobe, keys and contacts in,
// sprite position and motion status out.
interface player_motion_fsm_if #(
  parameter int ROPES = 6
);
  logic                   startOfFrame;
  logic                   leftPressed;
  logic                   rightPressed;
  logic                   upPressed;
  logic                   downPressed;
  logic                   onBlock;
  logic [3:0]             HitEdgeCode;
  logic                   collision;
  logic [ROPES-1:0]       ropeCollisions;
  logic [2*ROPES-1:0]     electroStatus;
  logic signed [15:0]     addedSpeed;
  logic signed [10:0]     topLeftX;
  logic signed [10:0]     topLeftY;
  logic [1:0]             motionState;
  logic [7:0]             stunCount;

  modport master (
    output startOfFrame, leftPressed, rightPressed, upPressed, downPressed,
    output onBlock, HitEdgeCode, collision, ropeCollisions, electroStatus, addedSpeed,
    input  topLeftX, topLeftY, motionState, stunCount
  );

  modport slave (
    input  startOfFrame, leftPressed, rightPressed, upPressed, downPressed,
    input  onBlock, HitEdgeCode, collision, ropeCollisions, electroStatus, addedSpeed,
    output topLeftX, topLeftY, motionState, stunCount
  );
endinterface

// File: rtl/player_motion_fsm.sv
// Player sprite motion controller: GROUND/AIR/CLIMB/STUN FSM with fixed-point X/Y
// integration, gravity, jumping, rope climbing/drift and electrified-rope stun.
module player_motion_fsm #(
  parameter int ROPES       = 6,
  parameter int FP_SHIFT    = 6,
  parameter int INITIAL_X   = 280,
  parameter int INITIAL_Y   = 185,
  parameter int WALK_SPEED  = 200,
  parameter int CLIMB_SPEED = 100,
  parameter int JUMP_SPEED  = 300,
  parameter int GRAVITY     = 10,
  parameter int MAX_FALL    = 230,
  parameter int X_MIN       = -9,
  parameter int X_MAX       = 570,
  parameter int Y_MAX       = 420,
  parameter int STUN_FRAMES = 150
) (
  input logic                clk,
  input logic                resetN,
  player_motion_fsm_if.slave bus
);
  typedef enum logic [1:0] {GROUND = 2'd0, AIR = 2'd1, CLIMB = 2'd2, STUN = 2'd3} state_t;

  localparam int                 FP_ONE    = 1 << FP_SHIFT;
  localparam logic signed [31:0] X_MIN_FP  = X_MIN * FP_ONE;
  localparam logic signed [31:0] X_MAX_FP  = X_MAX * FP_ONE;
  localparam logic signed [31:0] Y_MAX_FP  = Y_MAX * FP_ONE;
  localparam logic signed [31:0] INIT_X_FP = INITIAL_X * FP_ONE;
  localparam logic signed [31:0] INIT_Y_FP = INITIAL_Y * FP_ONE;
  localparam logic signed [31:0] WALK_V    = WALK_SPEED;
  localparam logic signed [31:0] CLIMB_V   = CLIMB_SPEED;
  localparam logic signed [31:0] JUMP_V    = JUMP_SPEED;
  localparam logic signed [31:0] GRAV_V    = GRAVITY;
  localparam logic signed [31:0] FALL_V    = MAX_FALL;
  localparam logic [7:0]         STUN_INIT = 8'(STUN_FRAMES - 1);

  state_t             state;
  logic signed [31:0] x_fp, y_fp, xspeed, yspeed;
  logic [7:0]         stun_cnt;
  logic               hazard;

  logic               footing, on_rope, live_hit, hazard_now, floor_hit, land;
  logic [ROPES-1:0]   live;
  logic signed [31:0] x_px, x_sum, x_next, y_sum, y_grav, y_fall;
  logic signed [31:0] drift, walk_speed, climb_speed;
  logic               unused_edges;

  assign footing      = bus.onBlock & bus.HitEdgeCode[0];
  assign on_rope      = |bus.ropeCollisions;
  assign unused_edges = bus.HitEdgeCode[1] ^ bus.HitEdgeCode[3];

  always_comb begin
    live = '0;
    for (int i = 0; i < ROPES; i++) begin
      live[i] = bus.ropeCollisions[i] && (bus.electroStatus[2*i +: 2] == 2'b10);
    end
  end

  // A live rope touched at any time during the frame counts, even if released before SOF
  assign live_hit   = |live;
  assign hazard_now = hazard | live_hit;

  assign drift     = 32'(bus.addedSpeed);
  assign x_px      = x_fp >>> FP_SHIFT;
  assign x_sum     = x_fp + xspeed;
  assign x_next    = (x_sum < X_MIN_FP) ? X_MIN_FP : (x_sum > X_MAX_FP) ? X_MAX_FP : x_sum;
  assign y_sum     = y_fp + yspeed;
  assign floor_hit = y_sum > Y_MAX_FP;
  assign y_grav    = yspeed + GRAV_V;
  assign y_fall    = (y_grav > FALL_V) ? FALL_V : y_grav;
  assign land      = footing && !yspeed[31];

  always_comb begin
    walk_speed = drift;
    if (bus.rightPressed && !bus.leftPressed && (x_px < X_MAX)) begin
      walk_speed = WALK_V;
    end else if (bus.leftPressed && !bus.rightPressed && (x_px > X_MIN)) begin
      walk_speed = -WALK_V;
    end
  end

  always_comb begin
    climb_speed = '0;
    if (bus.upPressed && !bus.downPressed) begin
      climb_speed = -CLIMB_V;
    end else if (bus.downPressed && !bus.upPressed) begin
      climb_speed = CLIMB_V;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= AIR;
      x_fp     <= INIT_X_FP;
      y_fp     <= INIT_Y_FP;
      xspeed   <= '0;
      yspeed   <= '0;
      stun_cnt <= '0;
      hazard   <= 1'b0;
    end else begin
      if (bus.startOfFrame) begin
        hazard <= 1'b0;
      end else if (live_hit) begin
        hazard <= 1'b1;
      end

      if (bus.startOfFrame) begin
        y_fp <= floor_hit ? Y_MAX_FP : y_sum;
        if (state == STUN) begin
          // X stays frozen; Y keeps falling until something catches the sprite
          yspeed <= (floor_hit || land) ? '0 : y_fall;
          if (stun_cnt == 8'd0) begin
            state <= (footing || floor_hit) ? GROUND : AIR;
          end else begin
            stun_cnt <= stun_cnt - 8'd1;
          end
        end else begin
          x_fp <= x_next;
          if (hazard_now) begin
            state    <= STUN;
            xspeed   <= '0;
            yspeed   <= '0;
            stun_cnt <= STUN_INIT;
          end else if (floor_hit) begin
            xspeed <= walk_speed;
            state  <= GROUND;
            yspeed <= '0;
          end else begin
            xspeed <= walk_speed;
            case (state)
              GROUND: begin
                yspeed <= '0;
                if (on_rope && (bus.upPressed || bus.downPressed)) begin
                  state <= CLIMB;
                end else if (bus.upPressed) begin
                  state  <= AIR;
                  yspeed <= -JUMP_V;
                end else if (!footing) begin
                  state <= AIR;
                end
              end
              AIR: begin
                if (on_rope) begin
                  state  <= CLIMB;
                  yspeed <= '0;
                end else if (land) begin
                  state  <= GROUND;
                  yspeed <= '0;
                end else if (bus.collision && bus.HitEdgeCode[2] && yspeed[31]) begin
                  yspeed <= '0;
                end else begin
                  yspeed <= y_fall;
                end
              end
              CLIMB: begin
                if (!on_rope) begin
                  state  <= AIR;
                  yspeed <= '0;
                end else begin
                  yspeed <= climb_speed;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.topLeftX    = 11'(x_px);
  assign bus.topLeftY    = 11'(y_fp >>> FP_SHIFT);
  assign bus.motionState = state;
  assign bus.stunCount   = stun_cnt;
endmodule
